// File: rtl/multicycle_controller_if.sv
// Control-unit bus: instruction fields and flags in, datapath selects and write enables out.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [1:0] resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite;
  logic       pcwrite;
  logic       regwrite;
  logic       memwrite;
  logic       illegalop;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, zero,
    output immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
           irwrite, pcwrite, regwrite, memwrite, illegalop, state
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
           irwrite, pcwrite, regwrite, memwrite, illegalop, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main controller: Moore sequencer, ALU decoder and immediate-type select.
// Write enables are gated by the active-low reset so nothing writes while reset is held.
module multicycle_controller (
  input  logic                         clk,
  input  logic                         reset,
  multicycle_controller_if.master      bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t     st, nxt;
  logic [1:0] aluop;
  logic       pcupdate, branch;
  logic       irw, rw, mw, ill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st <= FETCH;
    else        st <= nxt;
  end

  always_comb begin
    nxt           = FETCH;
    aluop         = 2'b00;
    pcupdate      = 1'b0;
    branch        = 1'b0;
    irw           = 1'b0;
    rw            = 1'b0;
    mw            = 1'b0;
    ill           = 1'b0;
    bus.alusrca   = 2'b00;
    bus.alusrcb   = 2'b00;
    bus.resultsrc = 2'b00;
    bus.adrsrc    = 1'b0;
    case (st)
      FETCH: begin
        nxt           = DECODE;
        irw           = 1'b1;
        bus.alusrcb   = 2'b10;
        bus.resultsrc = 2'b10;
        pcupdate      = 1'b1;
      end
      DECODE: begin
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b01;
        case (bus.op)
          OP_LOAD, OP_STORE: nxt = MEMADR;
          OP_R:              nxt = EXECUTER;
          OP_I:              nxt = EXECUTEI;
          OP_JAL:            nxt = JAL;
          OP_BEQ:            nxt = BEQ;
          default: begin
            nxt = FETCH;
            ill = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        nxt         = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
      end
      MEMREAD: begin
        nxt        = MEMWB;
        bus.adrsrc = 1'b1;
      end
      MEMWB: begin
        bus.resultsrc = 2'b01;
        rw            = 1'b1;
      end
      MEMWRITE: begin
        bus.adrsrc = 1'b1;
        mw         = 1'b1;
      end
      EXECUTER: begin
        nxt         = ALUWB;
        bus.alusrca = 2'b10;
        aluop       = 2'b10;
      end
      ALUWB: rw = 1'b1;
      EXECUTEI: begin
        nxt         = ALUWB;
        bus.alusrca = 2'b10;
        bus.alusrcb = 2'b01;
        aluop       = 2'b10;
      end
      JAL: begin
        nxt         = ALUWB;
        bus.alusrca = 2'b01;
        bus.alusrcb = 2'b10;
        pcupdate    = 1'b1;
      end
      BEQ: begin
        bus.alusrca = 2'b10;
        aluop       = 2'b01;
        branch      = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    bus.alucontrol = 3'b000;
    case (aluop)
      2'b01: bus.alucontrol = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  bus.alucontrol = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  bus.alucontrol = 3'b101;
          3'b110:  bus.alucontrol = 3'b011;
          3'b111:  bus.alucontrol = 3'b010;
          default: bus.alucontrol = 3'b000;
        endcase
      end
      default: bus.alucontrol = 3'b000;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_STORE: bus.immsrc = 2'b01;
      OP_BEQ:   bus.immsrc = 2'b10;
      OP_JAL:   bus.immsrc = 2'b11;
      default:  bus.immsrc = 2'b00;
    endcase
  end

  assign bus.state     = st;
  assign bus.irwrite   = irw & reset;
  assign bus.pcwrite   = (pcupdate | (branch & bus.zero)) & reset;
  assign bus.regwrite  = rw & reset;
  assign bus.memwrite  = mw & reset;
  assign bus.illegalop = ill & reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and random instruction streams
// compared cycle by cycle against a per-instruction behavioural model.
module tb_multicycle_controller;

  logic clk;
  logic reset;
  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] ITY  = 7'b0010011;
  localparam logic [6:0] JALO = 7'b1101111;
  localparam logic [6:0] BEQO = 7'b1100011;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] imm;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] res;
    logic       adr;
    logic [2:0] alu;
    logic       ir;
    logic       pc;
    logic       rw;
    logic       mw;
    logic       ill;
  } ctl_t;

  int tests = 0;
  int fails = 0;
  int path[$];
  ctl_t obs, exp_c;

  function automatic bit legal(input logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RTY) || (o == ITY) || (o == JALO) || (o == BEQO);
  endfunction

  // Visited states for one instruction, from Fetch up to its last state.
  task automatic set_path(input logic [6:0] o);
    case (o)
      LW:       path = '{0, 1, 2, 3, 4};
      SW:       path = '{0, 1, 2, 5};
      RTY:      path = '{0, 1, 6, 7};
      ITY:      path = '{0, 1, 8, 7};
      JALO:     path = '{0, 1, 9, 7};
      BEQO:     path = '{0, 1, 10};
      default:  path = '{0, 1};
    endcase
  endtask

  // Expected controls for a given visited step, from the per-state output table.
  function automatic ctl_t exp_ctl(input int s, input logic [6:0] o, input logic [2:0] f3,
                                   input logic f7, input logic z, input bit in_reset);
    ctl_t c = '0;
    c.st  = 4'(s);
    c.imm = (o == SW) ? 2'b01 : (o == BEQO) ? 2'b10 : (o == JALO) ? 2'b11 : 2'b00;
    case (s)
      0:  begin c.srcb = 2'b10; c.res = 2'b10; c.ir = 1'b1; c.pc = 1'b1; end
      1:  begin c.srca = 2'b01; c.srcb = 2'b01; c.ill = !legal(o); end
      2:  begin c.srca = 2'b10; c.srcb = 2'b01; end
      3:  c.adr = 1'b1;
      4:  begin c.res = 2'b01; c.rw = 1'b1; end
      5:  begin c.adr = 1'b1; c.mw = 1'b1; end
      6:  c.srca = 2'b10;
      7:  c.rw = 1'b1;
      8:  begin c.srca = 2'b10; c.srcb = 2'b01; end
      9:  begin c.srca = 2'b01; c.srcb = 2'b10; c.pc = 1'b1; end
      10: begin c.srca = 2'b10; c.pc = z; end
      default: ;
    endcase
    if (s == 10) c.alu = 3'b001;
    else if (s == 6 || s == 8) begin
      case (f3)
        3'b000:  c.alu = (o == RTY && f7) ? 3'b001 : 3'b000;
        3'b010:  c.alu = 3'b101;
        3'b110:  c.alu = 3'b011;
        3'b111:  c.alu = 3'b010;
        default: c.alu = 3'b000;
      endcase
    end
    if (in_reset) begin
      c.ir = 1'b0; c.pc = 1'b0; c.rw = 1'b0; c.mw = 1'b0; c.ill = 1'b0;
    end
    return c;
  endfunction

  function automatic ctl_t observe();
    ctl_t c;
    c.st  = bus.state;     c.imm = bus.immsrc;   c.srca = bus.alusrca;
    c.srcb = bus.alusrcb;  c.res = bus.resultsrc; c.adr = bus.adrsrc;
    c.alu = bus.alucontrol; c.ir = bus.irwrite;  c.pc = bus.pcwrite;
    c.rw  = bus.regwrite;  c.mw  = bus.memwrite; c.ill = bus.illegalop;
    return c;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bus.op = LW; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    obs = observe(); exp_c = exp_ctl(0, LW, 3'b000, 1'b0, 1'b0, 1'b1);
    tests++;
    if (obs !== exp_c) begin
      fails++; $display("FAIL reset_hold got=%h exp=%h", obs, exp_c);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    obs = observe(); exp_c = exp_ctl(0, LW, 3'b000, 1'b0, 1'b0, 1'b0);
    tests++;
    if (obs !== exp_c) begin
      fails++; $display("FAIL reset_release got=%h exp=%h", obs, exp_c);
    end
    @(posedge clk); #1;
    foreach (path[i]) ;
    set_path(LW);
    for (int i = 1; i < path.size(); i++) begin
      @(negedge clk);
      obs = observe(); exp_c = exp_ctl(path[i], LW, 3'b000, 1'b0, 1'b0, 1'b0);
      tests++;
      if (obs !== exp_c) begin
        fails++; $display("FAIL reset_first_lw step=%0d got=%h exp=%h", i, obs, exp_c);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_instructions();
    logic [6:0] dop [11] = '{LW, SW, BEQO, BEQO, RTY, ITY, RTY, ITY, JALO, 7'b1111111, RTY};
    logic [2:0] df3 [11] = '{3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd7, 3'd0, 3'd0, 3'd6};
    logic       df7 [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int         dz  [11] = '{2, 2, 1, 0, 2, 2, 2, 2, 2, 2, 2};
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7;
    int         zm;
    for (int n = 0; n < 211; n++) begin
      if (n < 11) begin
        o = dop[n]; f3 = df3[n]; f7 = df7[n]; zm = dz[n];
      end else begin
        case ($urandom_range(0, 6))
          0: o = LW; 1: o = SW; 2: o = RTY; 3: o = ITY; 4: o = JALO; 5: o = BEQO;
          default: o = 7'($urandom);
        endcase
        f3 = 3'($urandom); f7 = 1'($urandom); zm = 2;
      end
      bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7;
      set_path(o);
      for (int i = 0; i < path.size(); i++) begin
        bus.zero = (zm == 2) ? 1'($urandom) : 1'(zm);
        @(negedge clk);
        obs = observe(); exp_c = exp_ctl(path[i], o, f3, f7, bus.zero, 1'b0);
        tests++;
        if (obs !== exp_c) begin
          fails++;
          $display("FAIL instr n=%0d op=%b f3=%b f7=%b step=%0d got=%h exp=%h",
                   n, o, f3, f7, i, obs, exp_c);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // Abort a store in MemAdr and again in MemWrite; reset must take effect without a clock.
  task automatic test_reset_abort();
    for (int k = 0; k < 2; k++) begin
      bus.op = SW; bus.funct3 = 3'd2; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
      repeat (k == 0 ? 2 : 3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      obs = observe(); exp_c = exp_ctl(0, SW, 3'd2, 1'b0, 1'b0, 1'b1);
      tests++;
      if (obs !== exp_c) begin
        fails++; $display("FAIL abort_async k=%0d got=%h exp=%h", k, obs, exp_c);
      end
      @(posedge clk); #1;
      obs = observe();
      tests++;
      if (obs !== exp_c) begin
        fails++; $display("FAIL abort_hold k=%0d got=%h exp=%h", k, obs, exp_c);
      end
      reset = 1'b1;
      set_path(SW);
      for (int i = 0; i < path.size(); i++) begin
        @(negedge clk);
        obs = observe(); exp_c = exp_ctl(path[i], SW, 3'd2, 1'b0, 1'b0, 1'b0);
        tests++;
        if (obs !== exp_c) begin
          fails++; $display("FAIL abort_resume k=%0d step=%0d got=%h exp=%h", k, i, obs, exp_c);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    test_reset();
    test_instructions();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit of the multi-cycle RV32I core. It decodes the latched instruction fields and sequences each instruction through a Moore state machine, sharing the single ALU and single memory port across fetch, address, execute and writeback steps. Every cycle it drives the datapath mux selects and the write enables, and it supplies `immsrc` to the immediate extender.

## Interface
Parameters: none.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low. State is forced while `reset`=0.
- `op` input 7: instr[6:0] from the instruction register.
- `funct3` input 3: instr[14:12].
- `funct7b5` input 1: instr[30].
- `zero` input 1: ALU zero flag.
- `immsrc` output 2: 00 I, 01 S, 10 B, 11 J.
- `alusrca` output 2: 00 PC, 01 OldPC, 10 rs1 data.
- `alusrcb` output 2: 00 rs2 data, 01 immext, 10 constant 4.
- `resultsrc` output 2: 00 ALUOut, 01 memory data, 10 ALU result.
- `adrsrc` output 1: memory address select; 0 PC, 1 Result.
- `alucontrol` output 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `irwrite`, `pcwrite`, `regwrite`, `memwrite` output 1 each: write enables.
- `illegalop` output 1: one-cycle pulse in Decode for an unsupported opcode.
- `state` output 4: current state encoding, for debug and verification.

## Operation
- States and encodings: Fetch 0, Decode 1, MemAdr 2, MemRead 3, MemWB 4, MemWrite 5, ExecuteR 6, ALUWB 7, ExecuteI 8, JAL 9, BEQ 10. Encodings 11–15 are unreachable; if entered, the next state is Fetch.
- Transitions:
  - Fetch→Decode.
  - Decode by `op`: 0000011 or 0100011→MemAdr; 0110011→ExecuteR; 0010011→ExecuteI; 1101111→JAL; 1100011→BEQ; any other opcode→Fetch with `illegalop`=1.
  - MemAdr: `op`=0000011→MemRead, otherwise MemWrite.
  - MemRead→MemWB→Fetch.
  - MemWrite→Fetch.
  - ExecuteR and ExecuteI→ALUWB→Fetch.
  - JAL→ALUWB.
  - BEQ→Fetch.
- Moore outputs per state (any signal not listed is 0 / 00):
  - Fetch: `adrsrc`=0, `irwrite`=1, `alusrcb`=10, ALUOp=00, `resultsrc`=10, PCUpdate=1.
  - Decode: `alusrca`=01, `alusrcb`=01, ALUOp=00.
  - MemAdr: `alusrca`=10, `alusrcb`=01, ALUOp=00.
  - MemRead: `adrsrc`=1.
  - MemWB: `resultsrc`=01, `regwrite`=1.
  - MemWrite: `adrsrc`=1, `memwrite`=1.
  - ExecuteR: `alusrca`=10, ALUOp=10.
  - ExecuteI: `alusrca`=10, `alusrcb`=01, ALUOp=10.
  - ALUWB: `regwrite`=1.
  - JAL: `alusrca`=01, `alusrcb`=10, PCUpdate=1.
  - BEQ: `alusrca`=10, ALUOp=01, Branch=1.
- `pcwrite` = PCUpdate | (Branch & `zero`).
- `immsrc` is combinational from `op`: 0100011→01; 1100011→10; 1101111→11; all other opcodes→00.
- ALU decoder:
  - ALUOp 00→000; ALUOp 01→001.
  - ALUOp 10, by `funct3`: 000→001 if `op`[5]&`funct7b5`, else 000; 010→101; 110→011; 111→010; any other funct3→000.
  - ALUOp 11→000.

## Timing
- Reset:
  - `reset`=0 immediately forces `state`=Fetch.
  - While `reset`=0, `irwrite`, `pcwrite`, `regwrite`, `memwrite` and `illegalop` are forced to 0. The other outputs show their Fetch values.
  - First Fetch write enables assert in the cycle during which `reset` rises.
- Reset asserted mid-instruction aborts it. No write enable is asserted after the asserting edge.
- Cycles per instruction, Fetch through last state: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
- Outputs are functions of `state` only, except:
  - `pcwrite` in BEQ, which follows `zero` in the same cycle.
  - `immsrc` and `alucontrol`, which follow `op`, `funct3` and `funct7b5` combinationally.
- `op` and `funct` fields are stable from Decode until the next Fetch, because the instruction register is written only in Fetch.

## Test plan
- Reset: hold `reset`=0 across 3 edges → `state`=0 and all write enables 0. Release `reset` → `irwrite`=`pcwrite`=1 that cycle; `state`=1 after the next edge.
- lw, `op`=0000011 → `state` sequence 0,1,2,3,4,0. `immsrc`=00. `regwrite`=1 only in state 4, with `resultsrc`=01.
- sw, `op`=0100011 → states 0,1,2,5,0. `immsrc`=01. `memwrite`=1 only in state 5, with `adrsrc`=1.
- beq, `op`=1100011:
  - `zero`=1 → states 0,1,10,0, with `pcwrite`=1 and `alucontrol`=001 in state 10.
  - `zero`=0 → `pcwrite`=0 in state 10.
- R-type sub, `op`=0110011, `funct3`=000, `funct7b5`=1 → `alucontrol`=001 in state 6. The same encoding with `op`=0010011 (addi) → `alucontrol`=000 in state 8. `funct3`=010 → 101.
- jal, `op`=1101111 → states 0,1,9,7,0. `immsrc`=11 and `pcwrite`=1 in state 9. Illegal `op`=1111111 → `illegalop`=1 in state 1, then state 0, with no writes.
